// File: rtl/serial_twos_comp_n_if.sv
// Beat bundle for the multi-lane serial negator.
// Master drives the input beat; slave returns the registered result.
interface serial_twos_comp_n_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2
);
    logic                in_valid;
    logic                in_sof;
    logic [CHANNELS-1:0] in_bit;
    logic [CHANNELS-1:0] negate;
    logic                out_valid;
    logic [CHANNELS-1:0] out_bit;
    logic                out_last;
    logic [CHANNELS-1:0] ovf;

    modport master (
        output in_valid, in_sof, in_bit, negate,
        input  out_valid, out_bit, out_last, ovf
    );

    modport slave (
        input  in_valid, in_sof, in_bit, negate,
        output out_valid, out_bit, out_last, ovf
    );
endinterface

// File: rtl/serial_twos_comp_n.sv
// Word-framed, multi-lane, LSB-first serial two's-complement negator
// with per-word bypass and most-negative overflow flag; 1-cycle latency.
module serial_twos_comp_n #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2
) (
    input  logic                 t_clock,
    input  logic                 r_n,
    serial_twos_comp_n_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]       r_idx;
    logic [CHANNELS-1:0] r_inv;
    logic [CHANNELS-1:0] r_neg;
    logic [CHANNELS-1:0] r_nz;
    logic                r_out_valid;
    logic [CHANNELS-1:0] r_out_bit;
    logic                r_out_last;
    logic [CHANNELS-1:0] r_ovf;

    logic [CW-1:0]       w_eidx;
    logic [CW-1:0]       w_idx_nxt;
    logic                w_first;
    logic                w_last;
    logic [CHANNELS-1:0] w_seek;
    logic [CHANNELS-1:0] w_neg;
    logic [CHANNELS-1:0] w_nz;
    logic [CHANNELS-1:0] w_out;
    logic [CHANNELS-1:0] w_inv_nxt;
    logic [CHANNELS-1:0] w_nz_nxt;
    logic [CHANNELS-1:0] w_ovf;

    // A sof beat is bit 0 whatever the counter says; partial words vanish.
    always_comb begin
        w_eidx    = bus.in_sof ? '0 : r_idx;
        w_first   = (w_eidx == '0);
        w_last    = (w_eidx == CW'(WIDTH - 1));
        w_idx_nxt = w_last ? '0 : w_eidx + CW'(1);
    end

    always_comb begin
        w_seek    = '0;
        w_neg     = '0;
        w_nz      = '0;
        w_out     = '0;
        w_inv_nxt = '0;
        w_nz_nxt  = '0;
        w_ovf     = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_seek[c]    = w_first | ~r_inv[c];
            w_neg[c]     = w_first ? bus.negate[c] : r_neg[c];
            w_nz[c]      = ~w_first & r_nz[c];
            w_out[c]     = bus.in_bit[c] ^ (w_neg[c] & ~w_seek[c]);
            w_inv_nxt[c] = ~w_seek[c] | bus.in_bit[c];
            w_nz_nxt[c]  = w_nz[c] | bus.in_bit[c];
            w_ovf[c]     = w_last & w_neg[c] & bus.in_bit[c] & ~w_nz[c];
        end
    end

    always_ff @(posedge t_clock or negedge r_n) begin
        if (!r_n) begin
            r_idx       <= '0;
            r_inv       <= '0;
            r_neg       <= '0;
            r_nz        <= '0;
            r_out_valid <= 1'b0;
            r_out_bit   <= '0;
            r_out_last  <= 1'b0;
            r_ovf       <= '0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_idx      <= w_idx_nxt;
                r_inv      <= w_inv_nxt;
                r_neg      <= w_neg;
                r_nz       <= w_nz_nxt;
                r_out_bit  <= w_out;
                r_out_last <= w_last;
                r_ovf      <= w_ovf;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_bit   = r_out_bit;
    assign bus.out_last  = r_out_last;
    assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_serial_twos_comp_n.sv
// Bench for serial_twos_comp_n: directed and random words checked
// against word-level arithmetic negation.
module tb_serial_twos_comp_n;
    localparam int W  = 8;
    localparam int CH = 2;

    logic t_clock = 1'b0;
    logic r_n     = 1'b0;
    int   n_vec   = 0;
    int   n_err   = 0;

    logic          exp_valid = 1'b0;
    logic [CH-1:0] exp_bit   = '0;
    logic          exp_last  = 1'b0;
    logic [CH-1:0] exp_ovf   = '0;

    serial_twos_comp_n_if #(.WIDTH(W), .CHANNELS(CH)) bus ();

    serial_twos_comp_n #(.WIDTH(W), .CHANNELS(CH)) dut (
        .t_clock (t_clock),
        .r_n     (r_n),
        .bus     (bus)
    );

    always #5 t_clock = ~t_clock;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out();
        chk("out_valid", 64'(bus.out_valid), 64'(exp_valid));
        chk("out_bit",   64'(bus.out_bit),   64'(exp_bit));
        chk("out_last",  64'(bus.out_last),  64'(exp_last));
        chk("ovf",       64'(bus.ovf),       64'(exp_ovf));
    endtask

    // Check the previous beat's result, then drive the next beat.
    task automatic beat(input logic v, input logic sof,
                        input logic [CH-1:0] b, input logic [CH-1:0] ng,
                        input logic [CH-1:0] eb, input logic el,
                        input logic [CH-1:0] eo);
        @(negedge t_clock);
        check_out();
        bus.in_valid = v;
        bus.in_sof   = sof;
        bus.in_bit   = b;
        bus.negate   = ng;
        exp_valid    = v;
        if (v) begin
            exp_bit  = eb;
            exp_last = el;
            exp_ovf  = eo;
        end
    endtask

    task automatic idle();
        beat(1'b0, 1'($urandom), CH'($urandom), CH'($urandom),
             '0, 1'b0, '0);
    endtask

    task automatic send_word(input logic [CH*W-1:0] xw,
                             input logic [CH-1:0] ng, input int nbits,
                             input bit sof, input bit gaps);
        logic [W-1:0]  x, r;
        logic [CH-1:0] ov, b, eb, nin;
        logic [W-1:0]  res [CH];
        logic [W-1:0]  src [CH];
        for (int c = 0; c < CH; c++) begin
            x      = xw[c*W +: W];
            src[c] = x;
            r      = ng[c] ? W'(0 - x) : x;
            res[c] = r;
            ov[c]  = ng[c] && (x == {1'b1, {(W-1){1'b0}}});
        end
        for (int i = 0; i < nbits; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) idle();
            for (int c = 0; c < CH; c++) begin
                b[c]  = src[c][i];
                eb[c] = res[c][i];
            end
            nin = (i == 0) ? ng : CH'($urandom);
            beat(1'b1, sof && (i == 0), b, nin, eb, (i == W-1),
                 (i == W-1) ? ov : '0);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_bit   = '0;
        bus.negate   = '0;

        idle();
        idle();
        @(negedge t_clock);
        r_n = 1'b1;
        idle();

        // basic negate, then bypass/independence
        send_word({8'($urandom), 8'h06}, 2'b01, W, 1, 0);
        send_word({8'h35, 8'h01}, 2'b01, W, 1, 0);
        // overflow corners
        send_word({8'h80, 8'h80}, 2'b11, W, 1, 0);
        send_word({8'h80, 8'h00}, 2'b01, W, 1, 0);
        send_word({8'h00, 8'h81}, 2'b11, W, 1, 0);
        idle();

        // abandoned partial word then a clean restart
        send_word({8'($urandom), 8'($urandom)}, 2'b11, 3, 1, 0);
        send_word({8'h03, 8'h03}, 2'b11, W, 1, 0);
        idle();

        // gaps across back-to-back words
        send_word({8'h06, 8'h06}, 2'b11, W, 1, 1);
        send_word({8'h7F, 8'h7F}, 2'b11, W, 0, 1);

        // random words, random bypass, gaps and mid-word negate noise
        for (int k = 0; k < 24; k++)
            send_word(16'($urandom), 2'($urandom), W,
                      bit'($urandom), bit'($urandom));
        idle();

        // async reset mid-word
        send_word({8'hFF, 8'hFF}, 2'b00, 4, 1, 0);
        @(negedge t_clock);
        check_out();
        #2;
        r_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        exp_valid = 1'b0;
        exp_bit   = '0;
        exp_last  = 1'b0;
        exp_ovf   = '0;
        check_out();
        idle();
        @(negedge t_clock);
        r_n = 1'b1;
        send_word({8'h06, 8'h06}, 2'b11, W, 0, 0);
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/serial_twos_comp_n.md
# serial_twos_comp_n

Multi-channel, word-framed serial two's-complement negator. It processes CHANNELS independent LSB-first bit streams of WIDTH-bit words that share one framing. Each channel follows the serial rule: pass bits through up to and including the first 1, then invert every later bit. Each channel also has a per-word negate enable and detects negation overflow (most-negative input). It sits between the serial sample sources and the serial accumulators, and generalises the single-stream inverter to fixed word length, multiple lanes and bypass mode.

## Interface
- WIDTH, 8, word length in bits; legal range 2..64.
- CHANNELS, 2, number of parallel serial lanes; legal range ≥1.
- CW, $clog2(WIDTH), width of the bit-index counter (derived; not overridable).

- t_clock  input  1  clock; all state updates on the rising edge.
- r_n  input  1  asynchronous active-low reset.
- in_valid  input  1  the bits on in_bit are valid this cycle.
- in_sof  input  1  start of word; meaningful only with in_valid.
- in_bit  input  CHANNELS  serial data, one bit per channel, LSB first.
- negate  input  CHANNELS  per-channel negate enable; sampled on bit 0 only.
- out_valid  output  1  the bits on out_bit are valid.
- out_bit  output  CHANNELS  result bits, LSB first.
- out_last  output  1  out_bit holds bit WIDTH-1 of a word.
- ovf  output  CHANNELS  negation overflow; valid only when out_last=1.

## Operation
- Shared bit counter idx (CW bits), 0..WIDTH-1. It advances only on in_valid. It wraps from WIDTH-1 to 0. in_valid with in_sof=1 forces the current bit to be treated as idx=0, and the counter goes to 1 on the next update.
- Per-channel state: SEEK or INV, plus neg_q (latched negate), plus nz (a 1 seen below the MSB).
- On a bit-0 beat (idx=0 or in_sof): neg_q ← negate[c]. The state is evaluated as SEEK for this bit.
- Per beat, when the effective neg=1:
  - In SEEK, out=in. If in=1, go to INV.
  - In INV, out=~in.
- Per beat, when the effective neg=0: out=in. The state still tracks, but has no effect.
- ovf[c] on the MSB beat = neg AND in_bit[c]=1 AND no 1 was seen on bits 0..WIDTH-2. This is negation of −2^(WIDTH−1); the output equals the input in that case.
- Zero input with neg=1 gives zero output and ovf=0.
- If in_sof arrives while a word is partial, the partial word is abandoned. No out_last is emitted for it, and the new word starts cleanly in every channel.
- When in_valid=0 there is no state change and out_valid=0. out_bit, out_last and ovf hold their last values.

## Timing
- Latency is exactly 1 cycle. out_valid, out_bit, out_last and ovf are registered from the beat sampled on the previous edge.
- There is no backpressure. The block accepts one beat per cycle at any in_valid duty cycle, and gaps do not disturb framing.
- out_last=1 exactly on the output beat for idx=WIDTH-1. ovf is updated on that beat and reads 0 on all other valid beats.
- r_n low, taken asynchronously, sets:
  - out_valid=0, out_last=0, out_bit=0, ovf=0
  - idx=0
  - all channels SEEK, neg_q=0, nz=0
- Reset released mid-word: the next valid beat is bit 0 regardless of in_sof.
- in_sof on the beat where idx=0 already: no special effect.
- Changing negate mid-word has no effect until the next bit 0.

## Test plan
- Basic negate, WIDTH=8, ch0 neg=1, input 6 (LSB-first 0,1,1,0,0,0,0,0) -> out 0,1,0,1,1,1,1,1 (0xFA). out_last on the 8th output beat, ovf=0.
- Bypass and independence: ch0 neg=1 input 0x01 and ch1 neg=0 input 0x35 in the same word -> ch0 0xFF, ch1 0x35.
- Overflow: neg=1, input 0x80 -> output 0x80 with ovf=1 on out_last. Input 0x00 -> 0x00, ovf=0. Input 0x81 -> 0x7F, ovf=0.
- Framing: 3 beats of a word, then in_sof with 0x03 and neg=1 -> no out_last for the partial word. The new word outputs 0xFD, and out_last lands 8 beats after the sof beat.
- Gaps and changes:
  - in_valid toggled 1/0 randomly across two back-to-back words (0x06, then 0x7F) with neg=1 -> 0xFA, then 0x81.
  - out_valid mirrors in_valid delayed by one cycle.
  - negate toggled mid-word has no effect.
- Async reset: assert r_n low mid-word (between clock edges) -> all outputs 0 immediately. After release, a fresh word 0x06 with neg=1 -> 0xFA.
